// File: rtl/stream_pkg.sv
// stream_pkg: shared FSM state encoding and default widths for the stream
// source block and its helpers.
package stream_pkg;

    // Default payload, burst-length and gap field widths
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int GAP_W   = 4;

    // Width of the stall statistics counter
    localparam int STALL_W = 16;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/stream_down_counter.sv
// stream_down_counter: loadable down counter with a zero flag. Used to time
// the idle gap between packets of a burst. Decrementing stops at zero.
module stream_down_counter #(
    parameter int W = stream_pkg::GAP_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/stream_source.sv
// stream_source: burst packet generator. On an accepted start it emits
// burst_len packets seed, seed+1, ... over a valid/ready handshake, with an
// optional idle gap between packets, then pulses done for one cycle.
// Optional feature: define STREAM_SOURCE_STATS_EN to build the saturating
// stall_count statistics counter; otherwise stall_count is tied to zero.
module stream_source #(
    parameter int DATA_W = stream_pkg::DATA_W,
    parameter int LEN_W  = stream_pkg::LEN_W,
    parameter int GAP_W  = stream_pkg::GAP_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [GAP_W-1:0]  gap,
    input  logic [DATA_W-1:0] seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] packet_out,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  sent_count,
    output logic [15:0]       stall_count
);

    import stream_pkg::*;

    stream_state_t    state;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;

    logic             handshake;
    logic             last_packet;
    logic             gap_load;
    logic [GAP_W-1:0] gap_load_value;
    logic             gap_dec;
    logic             gap_zero;

    assign handshake   = (state == SEND) && out_valid && out_ready;
    assign last_packet = ((sent_count + LEN_W'(1)) == len_q);

    // The counter is loaded with g-1 so that the GAP state lasts exactly g
    // cycles: the final GAP cycle is the one that sees the zero flag.
    assign gap_load       = handshake && !last_packet && (gap_q != '0);
    assign gap_load_value = gap_q - GAP_W'(1);
    assign gap_dec        = (state == GAP) && !gap_zero;

    stream_down_counter #(
        .W (GAP_W)
    ) u_gap_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (gap_load),
        .load_value (gap_load_value),
        .dec        (gap_dec),
        .zero       (gap_zero)
    );

    // Burst sequencer: captures the request, walks the payload sequence and
    // drives all handshake/status outputs from registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            packet_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
            len_q      <= '0;
            gap_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sent_count <= '0;
                        if (burst_len != '0) begin
                            len_q      <= burst_len;
                            gap_q      <= gap;
                            packet_out <= seed;
                            out_valid  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (handshake) begin
                        sent_count <= sent_count + LEN_W'(1);
                        if (last_packet) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            packet_out <= packet_out + DATA_W'(1);
                            if (gap_q != '0) begin
                                out_valid <= 1'b0;
                                state     <= GAP;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_zero) begin
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef STREAM_SOURCE_STATS_EN
    logic             start_accept;
    logic [STALL_W-1:0] stall_q;

    assign start_accept = (state == IDLE) && start;

    // Count cycles where a packet is offered but refused, saturating at max
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (start_accept) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
